// File: rtl/instr_issue_ctrl_pkg.sv
// Shared types and constants for the instruction issue sequencer.
package instr_issue_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_MEM  = 3'd3,
    S_WAIT_CUST = 3'd4,
    S_WAIT_JMP  = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  // Bit positions within the one-hot execution-class vector.
  localparam int CLS_ALU  = 0;
  localparam int CLS_CSR  = 1;
  localparam int CLS_SYS  = 2;
  localparam int CLS_JMP  = 3;
  localparam int CLS_MEM  = 4;
  localparam int CLS_CUST = 5;
  localparam int CLS_W    = 6;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_CUST_TO = 2'd2;

endpackage

// File: rtl/instr_issue_ctrl_classifier.sv
// Priority encoder: decoder op vectors -> one-hot execution class or illegal.
module issue_classifier
  import instr_issue_pkg::*;
(
  input  logic [31:0]      i_invalid,
  input  logic [18:0]      i_alu_op,
  input  logic [8:0]       i_jmp_op,
  input  logic [8:0]       i_mem_op,
  input  logic             i_cust_op,
  input  logic [5:0]       i_csr_op,
  input  logic [7:0]       i_mechie_op,
  output logic [CLS_W-1:0] o_class,
  output logic             o_illegal
);

  always_comb begin
    o_class   = '0;
    o_illegal = 1'b0;
    if (|i_invalid)        o_illegal         = 1'b1;
    else if (|i_mechie_op) o_class[CLS_SYS]  = 1'b1;
    else if (|i_csr_op)    o_class[CLS_CSR]  = 1'b1;
    else if (|i_jmp_op)    o_class[CLS_JMP]  = 1'b1;
    else if (|i_mem_op)    o_class[CLS_MEM]  = 1'b1;
    else if (i_cust_op)    o_class[CLS_CUST] = 1'b1;
    else if (|i_alu_op)    o_class[CLS_ALU]  = 1'b1;
    else                   o_illegal         = 1'b1; // no unit claims it
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Multi-cycle issue sequencer between fetch and the execution units:
// decode, dispatch to one class, wait on its handshake, or trap.
module instr_issue_ctrl
  import instr_issue_pkg::*;
#(
  parameter int CUST_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  output logic             dec_en,
  output logic [31:0]      dec_instr,
  input  logic [31:0]      dec_invalid,
  input  logic [18:0]      dec_alu_op,
  input  logic [8:0]       dec_jmp_op,
  input  logic [8:0]       dec_mem_op,
  input  logic             dec_cust_op,
  input  logic [5:0]       dec_csr_op,
  input  logic [7:0]       dec_mechie_op,
  output logic             issue_valid,
  output logic [5:0]       issue_unit,
  output logic [31:0]      issue_pc,
  output logic             mem_req,
  input  logic             mem_done,
  output logic             cust_req,
  input  logic             cust_done,
  input  logic             br_resolved,
  input  logic             br_taken,
  output logic             flush,
  output logic             trap_req,
  output logic [1:0]       trap_cause,
  output logic [31:0]      trap_pc,
  input  logic             trap_ack,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam int TO_W = (CUST_TIMEOUT > 1) ? $clog2(CUST_TIMEOUT) : 1;

  state_t           r_state, w_next;
  logic [31:0]      r_ir, r_pc;
  logic [CLS_W-1:0] r_class, w_cls;
  logic [TO_W-1:0]  r_cnt;
  logic [1:0]       r_cause, w_cause_val;
  logic [CNT_W-1:0] r_retired;
  logic             w_illegal, w_retire, w_set_cause, w_cnt_clr, w_cnt_inc;
  logic             w_cust_to;

  issue_classifier u_cls (
    .i_invalid   (dec_invalid),
    .i_alu_op    (dec_alu_op),
    .i_jmp_op    (dec_jmp_op),
    .i_mem_op    (dec_mem_op),
    .i_cust_op   (dec_cust_op),
    .i_csr_op    (dec_csr_op),
    .i_mechie_op (dec_mechie_op),
    .o_class     (w_cls),
    .o_illegal   (w_illegal)
  );

  // The ISSUE cycle is the first cust_req cycle, so the wait phase times out
  // once the incremented count reaches CUST_TIMEOUT-1.
  assign w_cust_to = (r_state == S_ISSUE) ? (CUST_TIMEOUT <= 1)
                   : ((32'(r_cnt) + 32'd1) >= (32'(CUST_TIMEOUT) - 32'd1));

  always_comb begin
    w_next      = r_state;
    if_ready    = 1'b0;
    dec_en      = 1'b0;
    dec_instr   = '0;
    issue_valid = 1'b0;
    issue_unit  = '0;
    issue_pc    = '0;
    mem_req     = 1'b0;
    cust_req    = 1'b0;
    flush       = 1'b0;
    trap_req    = 1'b0;
    trap_cause  = '0;
    trap_pc     = '0;
    w_retire    = 1'b0;
    w_set_cause = 1'b0;
    w_cause_val = '0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if_ready = 1'b1;
        if (if_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        dec_en    = 1'b1;
        dec_instr = r_ir;
        if (w_illegal) begin
          w_set_cause = 1'b1;
          w_cause_val = CAUSE_ILLEGAL;
          w_next      = S_TRAP;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue_valid = 1'b1;
        issue_unit  = r_class;
        issue_pc    = r_pc;
        w_next      = S_IDLE;
        if (r_class[CLS_MEM]) begin
          mem_req = 1'b1;
          if (mem_done) w_retire = 1'b1;
          else          w_next   = S_WAIT_MEM;
        end else if (r_class[CLS_CUST]) begin
          cust_req  = 1'b1;
          w_cnt_clr = 1'b1;
          if (cust_done) begin
            w_retire = 1'b1;
          end else if (w_cust_to) begin
            w_set_cause = 1'b1;
            w_cause_val = CAUSE_CUST_TO;
            w_next      = S_TRAP;
          end else begin
            w_next = S_WAIT_CUST;
          end
        end else if (r_class[CLS_JMP]) begin
          w_next = S_WAIT_JMP;
        end else begin
          w_retire = 1'b1;
          flush    = r_class[CLS_SYS];
        end
      end
      S_WAIT_MEM: begin
        mem_req = 1'b1;
        if (mem_done) begin
          w_retire = 1'b1;
          w_next   = S_IDLE;
        end
      end
      S_WAIT_CUST: begin
        cust_req  = 1'b1;
        w_cnt_inc = 1'b1;
        if (cust_done) begin
          w_retire = 1'b1;
          w_next   = S_IDLE;
        end else if (w_cust_to) begin
          w_set_cause = 1'b1;
          w_cause_val = CAUSE_CUST_TO;
          w_next      = S_TRAP;
        end
      end
      S_WAIT_JMP: begin
        if (br_resolved) begin
          w_retire = 1'b1;
          flush    = br_taken;
          w_next   = S_IDLE;
        end
      end
      S_TRAP: begin
        trap_req   = 1'b1;
        trap_cause = r_cause;
        trap_pc    = r_pc;
        if (trap_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_pc      <= '0;
      r_class   <= '0;
      r_cnt     <= '0;
      r_cause   <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && if_valid) begin
        r_ir <= if_instr;
        r_pc <= if_pc;
      end
      if (r_state == S_DECODE) r_class <= w_cls;
      if (w_set_cause)         r_cause <= w_cause_val;
      if (w_cnt_clr)           r_cnt   <= '0;
      else if (w_cnt_inc)      r_cnt   <= r_cnt + 1'b1;
      if (w_retire)            r_retired <= r_retired + 1'b1;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign retired = r_retired;

endmodule
